// File: rtl/pled_pkg.sv
// Shared types and constants for the PowerLED colour sequencer.
package pled_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_FADE_IN   = 2'd1,
      ST_HOLD      = 2'd2,
      ST_FADE_OUT  = 2'd3
   } pled_state_e;

   localparam logic [2:0] C_OFF     = 3'b000;
   localparam logic [2:0] C_RED     = 3'b001;
   localparam logic [2:0] C_GREEN   = 3'b010;
   localparam logic [2:0] C_YELLOW  = 3'b011;
   localparam logic [2:0] C_BLUE    = 3'b100;
   localparam logic [2:0] C_MAGENTA = 3'b101;
   localparam logic [2:0] C_CYAN    = 3'b110;
   localparam logic [2:0] C_WHITE   = 3'b111;

   // Colour walk 1..7; anything outside the walk (including OFF) restarts at red.
   function automatic logic [2:0] next_color(input logic [2:0] c);
      logic [2:0] n;
      case (c)
         C_RED:     n = C_GREEN;
         C_GREEN:   n = C_YELLOW;
         C_YELLOW:  n = C_BLUE;
         C_BLUE:    n = C_MAGENTA;
         C_MAGENTA: n = C_CYAN;
         C_CYAN:    n = C_WHITE;
         C_WHITE:   n = C_RED;
         default:   n = C_RED;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pled_pwm_timebase.sv
// Free-running PWM timebase: prescaler, PWM counter and end-of-period strobe.
module pled_pwm_timebase #(
   parameter int PRESCALE = 4,
   parameter int PWM_BITS = 8
) (
   input  logic                sys_clk,
   input  logic                reset,
   output logic [PWM_BITS-1:0] pwm_cnt,
   output logic                period_end
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic             pwm_tick;

   assign pwm_tick   = (pre_cnt == PRE_LAST);
   assign period_end = pwm_tick & (&pwm_cnt);

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else begin
         pre_cnt <= pwm_tick ? '0 : pre_cnt + PRE_W'(1);
         if (pwm_tick) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/pled_color_seq.sv
// Colour sequencer and PWM generator for the PowerLED RGB module.
// Fades each colour in, holds it, fades it out, then advances to the next colour.
module pled_color_seq
   import pled_pkg::*;
#(
   parameter int PRESCALE     = 4,
   parameter int PWM_BITS     = 8,
   parameter int FADE_STEP    = 1,
   parameter int HOLD_PERIODS = 256
) (
   input  logic                sys_clk,
   input  logic                reset,
   input  logic                pll_lock,
   input  logic                enable,
   input  logic [PWM_BITS-1:0] brightness,
   output logic                led_r,
   output logic                led_g,
   output logic                led_b,
   output logic [2:0]          color,
   output logic [1:0]          state,
   output logic                period_end
);

   localparam int HOLD_W = $clog2(HOLD_PERIODS + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
   localparam logic signed [PWM_BITS+1:0] STEP_S = (PWM_BITS + 2)'(FADE_STEP);

   // Fade arithmetic is done two bits wider and signed so neither direction can wrap.
   function automatic logic [PWM_BITS-1:0] fade_up(input logic [PWM_BITS-1:0] lvl,
                                                   input logic [PWM_BITS-1:0] tgt);
      logic signed [PWM_BITS+1:0] sum;
      sum = $signed({2'b00, lvl}) + STEP_S;
      if (sum >= $signed({2'b00, tgt})) begin
         return tgt;
      end
      return sum[PWM_BITS-1:0];
   endfunction

   function automatic logic [PWM_BITS-1:0] fade_down(input logic [PWM_BITS-1:0] lvl);
      logic signed [PWM_BITS+1:0] diff;
      diff = $signed({2'b00, lvl}) - STEP_S;
      if (diff <= 0) begin
         return '0;
      end
      return diff[PWM_BITS-1:0];
   endfunction

   logic [PWM_BITS-1:0] pwm_cnt;
   pled_state_e         state_q, state_nxt;
   logic [PWM_BITS-1:0] level_q, level_nxt;
   logic [PWM_BITS-1:0] lvl_up, lvl_dn;
   logic [2:0]          color_q, color_nxt;
   logic [HOLD_W-1:0]   hold_q, hold_nxt;
   logic [2:0]          led_p0;
   logic [2:0]          led_p1;

   pled_pwm_timebase #(
      .PRESCALE (PRESCALE),
      .PWM_BITS (PWM_BITS)
   ) u_timebase (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .pwm_cnt    (pwm_cnt),
      .period_end (period_end)
   );

   // Loss of lock overrides everything immediately, even a coincident period_end.
   always_ff @(posedge sys_clk) begin
      if (reset || !pll_lock) begin
         state_q <= ST_WAIT_LOCK;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      level_nxt = level_q;
      color_nxt = color_q;
      hold_nxt  = hold_q;
      lvl_up    = fade_up(level_q, brightness);
      lvl_dn    = fade_down(level_q);
      if (period_end) begin
         case (state_q)
            ST_WAIT_LOCK: begin
               level_nxt = '0;
               color_nxt = C_OFF;
               if (pll_lock && enable) begin
                  state_nxt = ST_FADE_IN;
                  color_nxt = C_RED;
               end
            end
            ST_FADE_IN: begin
               if (!enable) begin
                  state_nxt = ST_FADE_OUT;
               end else begin
                  level_nxt = lvl_up;
                  if (lvl_up >= brightness) begin
                     state_nxt = ST_HOLD;
                     hold_nxt  = '0;
                  end
               end
            end
            ST_HOLD: begin
               level_nxt = brightness;
               hold_nxt  = hold_q + HOLD_W'(1);
               if ((hold_q == HOLD_LAST) || !enable) begin
                  state_nxt = ST_FADE_OUT;
               end
            end
            ST_FADE_OUT: begin
               level_nxt = lvl_dn;
               if (lvl_dn == '0) begin
                  if (enable) begin
                     state_nxt = ST_FADE_IN;
                     color_nxt = next_color(color_q);
                  end else begin
                     state_nxt = ST_WAIT_LOCK;
                     color_nxt = C_OFF;
                  end
               end
            end
            default: begin
               state_nxt = ST_WAIT_LOCK;
            end
         endcase
      end
   end

   always_comb begin
      state  = state_q;
      color  = color_q;
      led_p0 = color_q & {3{pwm_cnt < level_q}};
   end

   // Stage p1: level/colour registers and the registered channel drive.
   always_ff @(posedge sys_clk) begin
      if (reset || !pll_lock) begin
         level_q <= '0;
         color_q <= C_OFF;
         hold_q  <= '0;
         led_p1  <= '0;
      end else begin
         level_q <= level_nxt;
         color_q <= color_nxt;
         hold_q  <= hold_nxt;
         led_p1  <= led_p0;
      end
   end

   assign led_r = led_p1[0];
   assign led_g = led_p1[1];
   assign led_b = led_p1[2];

endmodule

// File: tb/tb_pled_color_seq.sv
// Bench for pled_color_seq with a 16-cycle PWM period and a two-period hold.
module tb_pled_color_seq;

   typedef struct {
      logic [1:0] st;
      logic [2:0] col;
      int         dr;
      int         dg;
      int         db;
   } exp_t;

   logic       sys_clk = 1'b0;
   logic       reset;
   logic       pll_lock;
   logic       enable;
   logic [3:0] brightness;
   logic       led_r, led_g, led_b;
   logic [2:0] color;
   logic [1:0] state;
   logic       period_end;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];

   pled_color_seq #(
      .PRESCALE     (1),
      .PWM_BITS     (4),
      .FADE_STEP    (1),
      .HOLD_PERIODS (2)
   ) dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .pll_lock   (pll_lock),
      .enable     (enable),
      .brightness (brightness),
      .led_r      (led_r),
      .led_g      (led_g),
      .led_b      (led_b),
      .color      (color),
      .state      (state),
      .period_end (period_end)
   );

   always #5 sys_clk = ~sys_clk;

   // Expected per-period outcome: state/colour right after the update, and LED duty over the period.
   task automatic push_exp(input logic [1:0] st, input logic [2:0] col, input int lvl);
      exp_t e;
      e.st  = st;
      e.col = col;
      e.dr  = col[0] ? lvl : 0;
      e.dg  = col[1] ? lvl : 0;
      e.db  = col[2] ? lvl : 0;
      sb_q.push_back(e);
   endtask

   // Called just after an update edge; observes one full period and returns after the next update edge.
   task automatic step_period(output exp_t o, output bit pe_ok);
      o.st  = state;
      o.col = color;
      o.dr  = 0;
      o.dg  = 0;
      o.db  = 0;
      pe_ok = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge sys_clk);
         o.dr = o.dr + (led_r ? 1 : 0);
         o.dg = o.dg + (led_g ? 1 : 0);
         o.db = o.db + (led_b ? 1 : 0);
         if (period_end !== (i == 16)) pe_ok = 1'b0;
      end
      @(posedge sys_clk);
      #1;
   endtask

   task automatic sync_pe(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clk);
         if (period_end === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      pll_lock   = 1'b0;
      enable     = 1'b0;
      brightness = 4'd0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      n_cmp++;
      if ({state, color, led_r, led_g, led_b, period_end} !== 9'd0) begin
         n_bad++;
         $display("FAIL reset_state: state=%0d color=%0d leds=%b%b%b pe=%b, want all 0",
                  state, color, led_b, led_g, led_r, period_end);
      end
   endtask

   task automatic test_no_lock();
      @(posedge sys_clk);
      #1;
      reset  = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         n_cmp++;
         if ({state, color, led_r, led_g, led_b} !== 8'd0) begin
            n_bad++;
            $display("FAIL no_lock[%0d]: state=%0d color=%0d leds=%b%b%b, want all 0",
                     i, state, color, led_b, led_g, led_r);
         end
      end
   endtask

   task automatic test_fade_cycle();
      exp_t o, e;
      bit   pe, ok;
      @(posedge sys_clk);
      #1;
      pll_lock   = 1'b1;
      brightness = 4'd4;
      enable     = 1'b1;
      sync_pe(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL fade_sync: no period_end within 40 cycles, want one within 16");
      end
      for (int c = 1; c <= 7; c++) begin
         push_exp(2'd1, 3'(c), 0);
         push_exp(2'd1, 3'(c), 1);
         push_exp(2'd1, 3'(c), 2);
         push_exp(2'd1, 3'(c), 3);
         push_exp(2'd2, 3'(c), 4);
         push_exp(2'd2, 3'(c), 4);
         push_exp(2'd3, 3'(c), 4);
         push_exp(2'd3, 3'(c), 3);
         push_exp(2'd3, 3'(c), 2);
         push_exp(2'd3, 3'(c), 1);
      end
      push_exp(2'd1, 3'd1, 0);
      for (int k = 0; sb_q.size() > 0; k++) begin
         step_period(o, pe);
         e = sb_q.pop_front();
         n_cmp++;
         if (o.st !== e.st || o.col !== e.col || o.dr != e.dr || o.dg != e.dg || o.db != e.db || !pe) begin
            n_bad++;
            $display("FAIL fade_cycle[%0d]: got st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=%0d, want st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=1",
                     k, o.st, o.col, o.dr, o.dg, o.db, pe, e.st, e.col, e.dr, e.dg, e.db);
         end
      end
   endtask

   task automatic test_lock_drop();
      exp_t o, e;
      bit   pe, ok;
      push_exp(2'd1, 3'd1, 1);
      push_exp(2'd1, 3'd1, 2);
      push_exp(2'd1, 3'd1, 3);
      for (int k = 0; sb_q.size() > 0; k++) begin
         step_period(o, pe);
         e = sb_q.pop_front();
         n_cmp++;
         if (o.st !== e.st || o.col !== e.col || o.dr != e.dr || o.dg != e.dg || o.db != e.db || !pe) begin
            n_bad++;
            $display("FAIL lock_pre[%0d]: got st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=%0d, want st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=1",
                     k, o.st, o.col, o.dr, o.dg, o.db, pe, e.st, e.col, e.dr, e.dg, e.db);
         end
      end
      n_cmp++;
      if (state !== 2'd2) begin
         n_bad++;
         $display("FAIL lock_in_hold: state=%0d, want 2", state);
      end
      repeat (3) @(posedge sys_clk);
      #1;
      pll_lock = 1'b0;
      @(posedge sys_clk);
      #1;
      pll_lock = 1'b1;
      @(negedge sys_clk);
      n_cmp++;
      if ({state, color, led_r, led_g, led_b} !== 8'd0) begin
         n_bad++;
         $display("FAIL lock_drop: state=%0d color=%0d leds=%b%b%b, want all 0",
                  state, color, led_b, led_g, led_r);
      end
      sync_pe(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL lock_sync: no period_end within 40 cycles, want one within 16");
      end
      push_exp(2'd1, 3'd1, 0);
      push_exp(2'd1, 3'd1, 1);
      push_exp(2'd1, 3'd1, 2);
      push_exp(2'd1, 3'd1, 3);
      for (int k = 0; sb_q.size() > 0; k++) begin
         step_period(o, pe);
         e = sb_q.pop_front();
         n_cmp++;
         if (o.st !== e.st || o.col !== e.col || o.dr != e.dr || o.dg != e.dg || o.db != e.db || !pe) begin
            n_bad++;
            $display("FAIL lock_restart[%0d]: got st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=%0d, want st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=1",
                     k, o.st, o.col, o.dr, o.dg, o.db, pe, e.st, e.col, e.dr, e.dg, e.db);
         end
      end
   endtask

   task automatic test_brightness_hold();
      exp_t o, e;
      bit   pe;
      brightness = 4'd15;
      push_exp(2'd2, 3'd1, 4);
      push_exp(2'd2, 3'd1, 15);
      for (int l = 15; l >= 1; l--) push_exp(2'd3, 3'd1, l);
      push_exp(2'd1, 3'd2, 0);
      for (int k = 0; sb_q.size() > 0; k++) begin
         step_period(o, pe);
         e = sb_q.pop_front();
         n_cmp++;
         if (o.st !== e.st || o.col !== e.col || o.dr != e.dr || o.dg != e.dg || o.db != e.db || !pe) begin
            n_bad++;
            $display("FAIL bright_hold[%0d]: got st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=%0d, want st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=1",
                     k, o.st, o.col, o.dr, o.dg, o.db, pe, e.st, e.col, e.dr, e.dg, e.db);
         end
      end
   endtask

   task automatic test_enable_drop();
      exp_t o, e;
      bit   pe;
      brightness = 4'd4;
      push_exp(2'd1, 3'd2, 1);
      step_period(o, pe);
      e = sb_q.pop_front();
      n_cmp++;
      if (o.st !== e.st || o.col !== e.col || o.dr != e.dr || o.dg != e.dg || o.db != e.db || !pe) begin
         n_bad++;
         $display("FAIL en_pre: got st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=%0d, want st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=1",
                  o.st, o.col, o.dr, o.dg, o.db, pe, e.st, e.col, e.dr, e.dg, e.db);
      end
      enable = 1'b0;
      push_exp(2'd1, 3'd2, 2);
      push_exp(2'd3, 3'd2, 2);
      push_exp(2'd3, 3'd2, 1);
      push_exp(2'd0, 3'd0, 0);
      for (int k = 0; sb_q.size() > 0; k++) begin
         step_period(o, pe);
         e = sb_q.pop_front();
         n_cmp++;
         if (o.st !== e.st || o.col !== e.col || o.dr != e.dr || o.dg != e.dg || o.db != e.db || !pe) begin
            n_bad++;
            $display("FAIL en_drop[%0d]: got st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=%0d, want st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=1",
                     k, o.st, o.col, o.dr, o.dg, o.db, pe, e.st, e.col, e.dr, e.dg, e.db);
         end
      end
   endtask

   task automatic test_zero_brightness();
      exp_t o, e;
      bit   pe;
      brightness = 4'd0;
      enable     = 1'b1;
      push_exp(2'd0, 3'd0, 0);
      push_exp(2'd1, 3'd1, 0);
      push_exp(2'd2, 3'd1, 0);
      push_exp(2'd2, 3'd1, 0);
      push_exp(2'd3, 3'd1, 0);
      push_exp(2'd1, 3'd2, 0);
      for (int k = 0; sb_q.size() > 0; k++) begin
         step_period(o, pe);
         e = sb_q.pop_front();
         n_cmp++;
         if (o.st !== e.st || o.col !== e.col || o.dr != e.dr || o.dg != e.dg || o.db != e.db || !pe) begin
            n_bad++;
            $display("FAIL zero_bright[%0d]: got st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=%0d, want st=%0d col=%0d duty=%0d/%0d/%0d pe_ok=1",
                     k, o.st, o.col, o.dr, o.dg, o.db, pe, e.st, e.col, e.dr, e.dg, e.db);
         end
      end
   endtask

   task automatic test_reset_mid();
      int gap;
      repeat (5) @(posedge sys_clk);
      #1;
      reset = 1'b1;
      @(posedge sys_clk);
      #1;
      reset = 1'b0;
      @(negedge sys_clk);
      n_cmp++;
      if ({state, color, led_r, led_g, led_b, period_end} !== 9'd0) begin
         n_bad++;
         $display("FAIL reset_mid: state=%0d color=%0d leds=%b%b%b pe=%b, want all 0",
                  state, color, led_b, led_g, led_r, period_end);
      end
      gap = -1;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge sys_clk);
         if (period_end === 1'b1) begin
            gap = i;
            break;
         end
      end
      n_cmp++;
      if (gap != 15) begin
         n_bad++;
         $display("FAIL reset_period: first period_end after %0d cycles (-1 = none), want 15", gap);
      end
   endtask

   initial begin
      test_reset();
      test_no_lock();
      test_fade_cycle();
      test_lock_drop();
      test_brightness_hold();
      test_enable_drop();
      test_zero_brightness();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
